cordic_rotate: RTL
==================

CORDIC_ROTATE -- requirements
Module: cordic_rotate

Interface
REQ-001 Parameter ITER, default 28, number of micro-rotations, legal 16..30.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse, sampled on rising clk.
REQ-005 phi  input  32  target angle, signed Q3.29 radians, sampled when start is accepted.
REQ-006 cos_out  output  32  cosine result, signed Q2.30.
REQ-007 sin_out  output  32  sine result, signed Q2.30.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse, results valid.

Function
REQ-010 The block SHALL compute cos(phi) and sin(phi) by iterative rotation-mode CORDIC, the inverse direction of the vectoring-mode angle unit.
REQ-011 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when counter==ITER-1, DONE->IDLE, or DONE->RUN if start is high.
REQ-012 On acceptance: x=K=652032874 (0.6072529350*2^30), y=0, z=folded phi, counter=0, quadrant flag captured.
REQ-013 Fold: phi>843314857 (pi/2) gives z=phi-1686629713 (pi) and neg=1; phi<-843314857 gives z=phi+1686629713 and neg=1; otherwise z=phi and neg=0.
REQ-014 Each RUN cycle i: d=sign(z); x-=d*(y>>>i); y+=d*(x>>>i); z-=d*atan(2^-i); arithmetic shifts, simultaneous update.
REQ-015 Internal x/y SHALL be 34 bits (2 guard LSBs). z SHALL be 32 bits Q3.29 with atan table entries rounded to nearest.
REQ-016 Latency: start sampled at edge E0; done high from E(ITER) to E(ITER+1); 28 cycles at default.
REQ-017 cos_out/sin_out SHALL update only on the RUN->DONE edge, negated if neg=1, and hold until the next completion or reset.
REQ-018 busy SHALL be high in RUN only; start in RUN SHALL be ignored and phi changes in RUN SHALL have no effect.
REQ-019 Accuracy: for |phi|<=pi, each output SHALL be within +/-8 LSB of the ideal Q2.30 value.
REQ-020 For |phi|>pi, results are unspecified, but the handshake timing SHALL be unchanged.

Reset
REQ-021 rst high SHALL force IDLE, counter=0, busy=0, done=0, cos_out=0, sin_out=0, and clear internal x/y/z, at any time including mid-RUN.
REQ-022 A start input coincident with rst high SHALL be ignored; the first acceptance SHALL occur on the first edge after rst deasserts.

Configuration
REQ-023 CORDIC_ROT_ROUND_EN defined: outputs SHALL be the 34-bit x/y rounded half-up to 32 bits.
REQ-024 CORDIC_ROT_ROUND_EN undefined: outputs SHALL be truncated, dropping the 2 guard LSBs; latency is identical in both cases.

Structure
REQ-025 Package cordic_pkg SHALL hold the width constants, the K constant, the pi and pi/2 constants in Q3.29, the 30-entry atan table in Q3.29, and the state typedef.
REQ-026 The design SHALL be a single iterative module with no sub-module; the table is indexed by counter.

Verification
REQ-027 phi=0 -> after 28 cycles done=1; cos_out=1073741824+/-8, sin_out=0+/-8.
REQ-028 phi=281104952 (pi/6) -> cos_out=929887697+/-8, sin_out=536870912+/-8.
REQ-029 phi=843314857 (pi/2) then phi=-1686629713 (-pi) back to back, the second start held high in the DONE cycle -> results (0, 2^30) then (-2^30, 0), +/-8; the second done follows 28 cycles after the DONE edge.
REQ-030 Start pulsed again 10 cycles into RUN with a different phi -> ignored; a single done at cycle 28 with the original result.
REQ-031 rst asserted at cycle 15 of RUN -> outputs, busy, and done are 0 immediately; a new start after rst gives the correct result 28 cycles later.
REQ-032 Sweep of 64 angles over [-pi, pi] run in both macro builds -> every output within +/-8 LSB of the double-precision model.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared widths, fixed-point constants, FSM encoding and the Q3.29
// arctangent table for the rotation-mode CORDIC.
package cordic_pkg;
    localparam int PHI_W = 32;
    localparam int XY_W  = 34;
    localparam int GUARD = XY_W - PHI_W;
    localparam int TAB_N = 30;
    localparam int CNT_W = $clog2(TAB_N);

    // K = 0.6072529350 in Q2.30; pi and pi/2 in Q3.29
    localparam logic signed [PHI_W-1:0] K_Q30       = 32'sd652032874;
    localparam logic signed [PHI_W-1:0] PI_Q29      = 32'sd1686629713;
    localparam logic signed [PHI_W-1:0] HALF_PI_Q29 = 32'sd843314857;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // atan(2^-i) in Q3.29, rounded to nearest
    function automatic logic signed [PHI_W-1:0] atan_q29(input logic [CNT_W-1:0] idx);
        logic signed [PHI_W-1:0] v;
        case (idx)
            5'd0:    v = 32'sd421657428;
            5'd1:    v = 32'sd248918915;
            5'd2:    v = 32'sd131521918;
            5'd3:    v = 32'sd66762579;
            5'd4:    v = 32'sd33510843;
            5'd5:    v = 32'sd16771758;
            5'd6:    v = 32'sd8387925;
            5'd7:    v = 32'sd4194219;
            5'd8:    v = 32'sd2097141;
            5'd9:    v = 32'sd1048575;
            5'd10:   v = 32'sd524288;
            5'd11:   v = 32'sd262144;
            5'd12:   v = 32'sd131072;
            5'd13:   v = 32'sd65536;
            5'd14:   v = 32'sd32768;
            5'd15:   v = 32'sd16384;
            5'd16:   v = 32'sd8192;
            5'd17:   v = 32'sd4096;
            5'd18:   v = 32'sd2048;
            5'd19:   v = 32'sd1024;
            5'd20:   v = 32'sd512;
            5'd21:   v = 32'sd256;
            5'd22:   v = 32'sd128;
            5'd23:   v = 32'sd64;
            5'd24:   v = 32'sd32;
            5'd25:   v = 32'sd16;
            5'd26:   v = 32'sd8;
            5'd27:   v = 32'sd4;
            5'd28:   v = 32'sd2;
            5'd29:   v = 32'sd1;
            default: v = '0;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC producing cos/sin of a Q3.29 angle, one
// micro-rotation per clock. Define CORDIC_ROT_ROUND_EN to round the outputs
// half-up instead of truncating the guard bits.
module cordic_rotate
    import cordic_pkg::*;
#(
    parameter int ITER = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] phi,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out,
    output logic        busy,
    output logic        done
);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(ITER - 1);
    localparam logic signed [XY_W-1:0] X_INIT  = XY_W'(K_Q30) <<< GUARD;
`ifdef CORDIC_ROT_ROUND_EN
    localparam logic signed [XY_W-1:0] OUT_BIAS = XY_W'(1) <<< (GUARD - 1);
`else
    localparam logic signed [XY_W-1:0] OUT_BIAS = '0;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [XY_W-1:0]  x_q, x_d, y_q, y_d;
    logic signed [PHI_W-1:0] z_q, z_d;
    logic                    neg_q, neg_d;
    logic [PHI_W-1:0]        cos_q, cos_d, sin_q, sin_d;

    logic signed [PHI_W-1:0] phi_s, z_fold, atan_i, z_it;
    logic                    neg_fold;
    logic signed [XY_W-1:0]  x_sh, y_sh, x_it, y_it, x_rnd, y_rnd;
    logic [PHI_W-1:0]        x_fin, y_fin;

    assign phi_s = phi;

    // Angles beyond +/-pi/2 are rotated by pi; the result is negated at the end.
    always_comb begin
        z_fold   = phi_s;
        neg_fold = 1'b0;
        if (phi_s > HALF_PI_Q29) begin
            z_fold   = phi_s - PI_Q29;
            neg_fold = 1'b1;
        end else if (phi_s < -HALF_PI_Q29) begin
            z_fold   = phi_s + PI_Q29;
            neg_fold = 1'b1;
        end
    end

    assign x_sh   = x_q >>> cnt_q;
    assign y_sh   = y_q >>> cnt_q;
    assign atan_i = atan_q29(cnt_q);

    always_comb begin
        if (z_q[PHI_W-1]) begin
            x_it = x_q + y_sh;
            y_it = y_q - x_sh;
            z_it = z_q + atan_i;
        end else begin
            x_it = x_q - y_sh;
            y_it = y_q + x_sh;
            z_it = z_q - atan_i;
        end
    end

    // Final outputs come from the last micro-rotation, not the registered x/y.
    assign x_rnd = x_it + OUT_BIAS;
    assign y_rnd = y_it + OUT_BIAS;
    assign x_fin = PHI_W'(x_rnd >>> GUARD);
    assign y_fin = PHI_W'(y_rnd >>> GUARD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        neg_d   = neg_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = z_fold;
                    neg_d   = neg_fold;
                end
            end
            ST_RUN: begin
                x_d   = x_it;
                y_d   = y_it;
                z_d   = z_it;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    cos_d   = neg_q ? -x_fin : x_fin;
                    sin_d   = neg_q ? -y_fin : y_fin;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = z_fold;
                    neg_d   = neg_fold;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            neg_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
endmodule
